// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes, flag bit indices and FSM encodings shared by alu_pipe
//
// Purpose: single source of the decode-stage op code values, the position of
// each bit in the 5-bit flags word, and the state encodings used by alu_pipe
// and alu_muldiv_iter.
// Optional feature macro: ALU_MULDIV_EN (the iterative helpers are only used
// when it is defined).
package alu_pkg;

    // Op codes as produced by the decode stage.
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_ADDC = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_CMP  = 4'd6;
    localparam logic [3:0] OP_LSH  = 4'd7;
    localparam logic [3:0] OP_LSHR = 4'd8;
    localparam logic [3:0] OP_ASHU = 4'd9;
    localparam logic [3:0] OP_MOV  = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;
    localparam logic [3:0] OP_DIVU = 4'd12;
    localparam logic [3:0] OP_REMU = 4'd13;

    // Bit positions inside the flags word {NEG, ZERO, FLAG, LOW, CARRY}.
    localparam int FLG_CARRY = 0;
    localparam int FLG_LOW   = 1;
    localparam int FLG_FLAG  = 2;
    localparam int FLG_ZERO  = 3;
    localparam int FLG_NEG   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        MD_MUL  = 2'd0,
        MD_DIVU = 2'd1,
        MD_REMU = 2'd2
    } md_op_e;

    function automatic logic is_iter_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

    function automatic md_op_e to_md_op(input logic [3:0] op);
        case (op)
            OP_MUL:  return MD_MUL;
            OP_DIVU: return MD_DIVU;
            default: return MD_REMU;
        endcase
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// rtl/alu_muldiv_iter.sv - radix-2 iterative unsigned multiply / divide / remainder
//
// Purpose: performs one shift-add (MUL) or restoring-division (DIVU/REMU) step
// per cycle for WIDTH cycles after a start pulse. Built only when ALU_MULDIV_EN
// is defined.
// Ports:
//   clk, reset   clock, synchronous active-high reset (aborts any operation)
//   start_i      latch operands and begin; only pulsed while not busy
//   op_i         MD_MUL / MD_DIVU / MD_REMU
//   a_i, b_i     operands (multiplicand/multiplier, dividend/divisor)
//   last_o       high during the cycle whose clock edge performs the final step
//   done_o       one-cycle pulse after the final step; result_o/flags_o valid
//   result_o     low product, quotient or remainder
//   flags_o      FLAG = product overflow or divide by zero, ZERO for MUL
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  md_op_e           op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             last_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [4:0]       flags_o
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    md_op_e             op_q, op_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] work_q, work_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               divz_q, divz_d;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;

    assign last_o = busy_q && (count_q == CNT_LAST);
    assign done_o = done_q;

    // work_q holds {high product, multiplier} for MUL and {remainder, quotient}
    // for division; both shift one bit per step.
    always_comb begin
        mul_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]}
                  + (work_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        div_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opnd_q};
        // Low bits of the difference are exact even though bit WIDTH is dropped.
        div_rem   = div_shift[WIDTH-1:0] - opnd_q;
    end

    always_comb begin
        op_d    = op_q;
        opnd_d  = opnd_q;
        work_d  = work_q;
        count_d = count_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        divz_d  = divz_q;
        if (start_i) begin
            op_d    = op_i;
            busy_d  = 1'b1;
            count_d = '0;
            divz_d  = (b_i == '0);
            if (op_i == MD_MUL) begin
                opnd_d = a_i;
                work_d = {{WIDTH{1'b0}}, b_i};
            end else begin
                opnd_d = b_i;
                work_d = {{WIDTH{1'b0}}, a_i};
            end
        end else if (busy_q) begin
            if (op_q == MD_MUL) begin
                work_d = {mul_sum, work_q[WIDTH-1:1]};
            end else begin
                // A zero divisor always "fits", giving an all-ones quotient and
                // leaving the dividend as the remainder.
                work_d = {(div_ge ? div_rem : div_shift[WIDTH-1:0]),
                          work_q[WIDTH-2:0], div_ge};
            end
            count_d = count_q + 1'b1;
            if (last_o) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q    <= MD_MUL;
            opnd_q  <= '0;
            work_q  <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            divz_q  <= 1'b0;
        end else begin
            op_q    <= op_d;
            opnd_q  <= opnd_d;
            work_q  <= work_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            divz_q  <= divz_d;
        end
    end

    always_comb begin
        result_o = '0;
        flags_o  = '0;
        case (op_q)
            MD_MUL: begin
                result_o           = work_q[WIDTH-1:0];
                flags_o[FLG_FLAG]  = |work_q[2*WIDTH-1:WIDTH];
                flags_o[FLG_ZERO]  = (work_q[WIDTH-1:0] == '0);
            end
            MD_DIVU: begin
                result_o          = work_q[WIDTH-1:0];
                flags_o[FLG_FLAG] = divz_q;
            end
            MD_REMU: begin
                result_o          = work_q[2*WIDTH-1:WIDTH];
                flags_o[FLG_FLAG] = divz_q;
            end
            default: begin
                result_o = '0;
                flags_o  = '0;
            end
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered ALU with valid/ready handshake, flags and tag passthrough
//
// Purpose: single-cycle arithmetic/logic/shift ops with latency 1; with
// ALU_MULDIV_EN defined, iterative MUL/DIVU/REMU with latency WIDTH+2.
// Without ALU_MULDIV_EN those ops report invalid_op and the FSM stays in IDLE.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   in_valid / in_ready    request handshake
//   op, a, b, carry_in     operation select and operands
//   tag_in                 opaque tag returned with the result
//   out_valid / out_ready  result handshake; outputs hold while stalled
//   result, flags          registered result and {NEG,ZERO,FLAG,LOW,CARRY}
//   invalid_op             op code not supported
//   tag_out                tag of the current result
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       flags,
    output logic             invalid_op,
    output logic [TAG_W-1:0] tag_out
);

    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [4:0]       flags_q, flags_d;
    logic             invalid_q, invalid_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    logic             accept;
    logic             iter_op;

    logic [WIDTH-1:0] sc_result;
    logic [4:0]       sc_flags;
    logic             sc_invalid;
    logic             cin_eff;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [WIDTH-1:0] neg_b;
    logic             amt_big;
    logic             neg_big;

    assign in_ready   = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept     = in_valid && in_ready;

    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign flags      = flags_q;
    assign invalid_op = invalid_q;
    assign tag_out    = tag_q;

`ifdef ALU_MULDIV_EN
    logic             md_start;
    logic             md_last;
    logic             md_done;
    logic [WIDTH-1:0] md_result;
    logic [4:0]       md_flags;
    logic [TAG_W-1:0] iter_tag_q, iter_tag_d;

    assign iter_op  = is_iter_op(op);
    assign md_start = accept && iter_op;

    alu_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk      (clk),
        .reset    (reset),
        .start_i  (md_start),
        .op_i     (to_md_op(op)),
        .a_i      (a),
        .b_i      (b),
        .last_o   (md_last),
        .done_o   (md_done),
        .result_o (md_result),
        .flags_o  (md_flags)
    );
`else
    assign iter_op = 1'b0;
`endif

    // Single-cycle datapath.
    always_comb begin
        cin_eff    = (op == OP_ADDC) && carry_in;
        sum_ext    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin_eff};
        diff_ext   = {1'b0, a} - {1'b0, b};
        neg_b      = -b;
        // Any bit above the shift-index field means a shift of WIDTH or more.
        amt_big    = |b[WIDTH-1:SHW];
        neg_big    = |neg_b[WIDTH-1:SHW];
        sc_result  = '0;
        sc_flags   = '0;
        sc_invalid = 1'b0;
        case (op)
            OP_ADD, OP_ADDC: begin
                sc_result           = sum_ext[WIDTH-1:0];
                sc_flags[FLG_CARRY] = sum_ext[WIDTH];
                sc_flags[FLG_FLAG]  = (a[MSB] == b[MSB]) && (sum_ext[MSB] != a[MSB]);
                sc_flags[FLG_ZERO]  = (sum_ext[WIDTH-1:0] == '0);
            end
            OP_SUB: begin
                sc_result           = diff_ext[WIDTH-1:0];
                sc_flags[FLG_CARRY] = diff_ext[WIDTH];
                sc_flags[FLG_FLAG]  = (a[MSB] != b[MSB]) && (diff_ext[MSB] != a[MSB]);
                sc_flags[FLG_ZERO]  = (diff_ext[WIDTH-1:0] == '0);
            end
            OP_AND: begin
                sc_result          = a & b;
                sc_flags[FLG_ZERO] = ((a & b) == '0);
            end
            OP_OR: begin
                sc_result          = a | b;
                sc_flags[FLG_ZERO] = ((a | b) == '0);
            end
            OP_XOR: begin
                sc_result          = a ^ b;
                sc_flags[FLG_ZERO] = ((a ^ b) == '0);
            end
            OP_CMP: begin
                sc_flags[FLG_NEG]  = $signed(a) < $signed(b);
                sc_flags[FLG_LOW]  = a < b;
                sc_flags[FLG_ZERO] = (a == b);
            end
            OP_LSH: begin
                if (!amt_big) sc_result = a << b[SHW-1:0];
            end
            OP_LSHR: begin
                if (!amt_big) sc_result = a >> b[SHW-1:0];
            end
            OP_ASHU: begin
                if (!b[MSB]) begin
                    if (!amt_big) sc_result = a << b[SHW-1:0];
                end else if (neg_big) begin
                    sc_result = {WIDTH{a[MSB]}};
                end else begin
                    // Kept out of a ternary so the shift stays signed.
                    sc_result = $signed(a) >>> neg_b[SHW-1:0];
                end
            end
            OP_MOV: begin
                sc_result = b;
            end
            default: begin
                sc_invalid = 1'b1;
            end
        endcase
    end

    // FSM next state and output register next state.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flags_d     = flags_q;
        invalid_d   = invalid_q;
        tag_d       = tag_q;
`ifdef ALU_MULDIV_EN
        iter_tag_d  = iter_tag_q;
`endif
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                // Loading over a result being consumed this cycle gives
                // back-to-back throughput with no bubble.
                if (accept && !iter_op) begin
                    out_valid_d = 1'b1;
                    result_d    = sc_result;
                    flags_d     = sc_flags;
                    invalid_d   = sc_invalid;
                    tag_d       = tag_in;
                end
`ifdef ALU_MULDIV_EN
                if (accept && iter_op) begin
                    state_d    = ST_ITER;
                    iter_tag_d = tag_in;
                end
`endif
            end
`ifdef ALU_MULDIV_EN
            ST_ITER: begin
                if (md_last) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (md_done) begin
                    out_valid_d = 1'b1;
                    result_d    = md_result;
                    flags_d     = md_flags;
                    invalid_d   = 1'b0;
                    tag_d       = iter_tag_q;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            invalid_q   <= 1'b0;
            tag_q       <= '0;
`ifdef ALU_MULDIV_EN
            iter_tag_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            invalid_q   <= invalid_d;
            tag_q       <= tag_d;
`ifdef ALU_MULDIV_EN
            iter_tag_q  <= iter_tag_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed self-checking bench for alu_pipe (WIDTH=16, TAG_W=4)
`timescale 1ns/1ps
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int W  = 16;
    localparam int TW = 4;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b1;
    logic          carry_in  = 1'b0;
    logic [3:0]    op        = 4'd0;
    logic [W-1:0]  a         = '0;
    logic [W-1:0]  b         = '0;
    logic [TW-1:0] tag_in    = '0;
    logic          in_ready;
    logic          out_valid;
    logic          invalid_op;
    logic [W-1:0]  result;
    logic [4:0]    flags;
    logic [TW-1:0] tag_out;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .a          (a),
        .b          (b),
        .carry_in   (carry_in),
        .tag_in     (tag_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .flags      (flags),
        .invalid_op (invalid_op),
        .tag_out    (tag_out)
    );

    // Drives one request, waits for acceptance, then returns the number of
    // cycles from the accept cycle to out_valid (1 = next cycle), or -1.
    task automatic issue(input logic [3:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input logic c, input logic [TW-1:0] t, output int lat);
        int n;
        op = o; a = aa; b = bb; carry_in = c; tag_in = t; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        lat = -1;
        if (in_ready) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            n = 1;
            while (!out_valid && n < 64) begin @(posedge clk); #1; n++; end
            if (out_valid) lat = n;
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else passed++;
        total++; if (result !== 16'h0000) $display("FAIL rst_result: got %h want 0000", result); else passed++;
        total++; if (flags !== 5'h00) $display("FAIL rst_flags: got %h want 00", flags); else passed++;
        total++; if (invalid_op !== 1'b0) $display("FAIL rst_invalid: got %b want 0", invalid_op); else passed++;
        total++; if (tag_out !== 4'h0) $display("FAIL rst_tag: got %h want 0", tag_out); else passed++;
        reset = 1'b0;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else passed++;
    endtask

    task automatic test_add();
        int lat;
        issue(OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 4'h3, lat);
        total++; if (lat !== 1) $display("FAIL add_latency: got %0d want 1", lat); else passed++;
        total++; if (result !== 16'h8000) $display("FAIL add_result: got %h want 8000", result); else passed++;
        total++; if (flags !== 5'h04) $display("FAIL add_flags: got %h want 04", flags); else passed++;
        total++; if (tag_out !== 4'h3) $display("FAIL add_tag: got %h want 3", tag_out); else passed++;
        total++; if (invalid_op !== 1'b0) $display("FAIL add_invalid: got %b want 0", invalid_op); else passed++;
        issue(OP_ADDC, 16'hFFFF, 16'h0000, 1'b1, 4'h5, lat);
        total++; if (result !== 16'h0000) $display("FAIL addc_result: got %h want 0000", result); else passed++;
        total++; if (flags !== 5'h09) $display("FAIL addc_flags: got %h want 09", flags); else passed++;
        issue(OP_ADD, 16'hFFFF, 16'h0000, 1'b1, 4'h6, lat);
        total++; if (result !== 16'hFFFF) $display("FAIL add_nocin_result: got %h want ffff", result); else passed++;
        total++; if (flags !== 5'h00) $display("FAIL add_nocin_flags: got %h want 00", flags); else passed++;
    endtask

    task automatic test_sub_cmp();
        int lat;
        issue(OP_SUB, 16'h0000, 16'h0001, 1'b0, 4'h1, lat);
        total++; if (result !== 16'hFFFF) $display("FAIL sub_result: got %h want ffff", result); else passed++;
        total++; if (flags !== 5'h01) $display("FAIL sub_flags: got %h want 01", flags); else passed++;
        issue(OP_CMP, 16'hFFFF, 16'h0001, 1'b0, 4'h2, lat);
        total++; if (result !== 16'h0000) $display("FAIL cmp_result: got %h want 0000", result); else passed++;
        total++; if (flags !== 5'h10) $display("FAIL cmp_neg_flags: got %h want 10", flags); else passed++;
        issue(OP_CMP, 16'h0005, 16'h0005, 1'b0, 4'h2, lat);
        total++; if (flags !== 5'h08) $display("FAIL cmp_eq_flags: got %h want 08", flags); else passed++;
        issue(OP_CMP, 16'h0001, 16'hFFFF, 1'b0, 4'h2, lat);
        total++; if (flags !== 5'h02) $display("FAIL cmp_low_flags: got %h want 02", flags); else passed++;
    endtask

    task automatic test_logic();
        int lat;
        issue(OP_AND, 16'hF0F0, 16'h0FF0, 1'b0, 4'h4, lat);
        total++; if (result !== 16'h00F0 || flags !== 5'h00) $display("FAIL and: got %h/%h want 00f0/00", result, flags); else passed++;
        issue(OP_XOR, 16'h5A5A, 16'h5A5A, 1'b0, 4'h4, lat);
        total++; if (result !== 16'h0000 || flags !== 5'h08) $display("FAIL xor: got %h/%h want 0000/08", result, flags); else passed++;
        issue(OP_OR, 16'h1200, 16'h0034, 1'b0, 4'h4, lat);
        total++; if (result !== 16'h1234) $display("FAIL or: got %h want 1234", result); else passed++;
        issue(OP_MOV, 16'h1111, 16'hABCD, 1'b0, 4'h4, lat);
        total++; if (result !== 16'hABCD) $display("FAIL mov: got %h want abcd", result); else passed++;
    endtask

    task automatic test_shifts();
        int lat;
        issue(OP_ASHU, 16'h8000, 16'hFFFD, 1'b0, 4'h7, lat);
        total++; if (result !== 16'hF000) $display("FAIL ashu_right: got %h want f000", result); else passed++;
        issue(OP_LSH, 16'h0001, 16'h0010, 1'b0, 4'h7, lat);
        total++; if (result !== 16'h0000 || flags !== 5'h00) $display("FAIL lsh_wide: got %h/%h want 0000/00", result, flags); else passed++;
        issue(OP_LSH, 16'h0001, 16'h000F, 1'b0, 4'h7, lat);
        total++; if (result !== 16'h8000) $display("FAIL lsh_15: got %h want 8000", result); else passed++;
        issue(OP_LSHR, 16'h8000, 16'h000F, 1'b0, 4'h7, lat);
        total++; if (result !== 16'h0001) $display("FAIL lshr_15: got %h want 0001", result); else passed++;
        issue(OP_LSHR, 16'hFFFF, 16'h0100, 1'b0, 4'h7, lat);
        total++; if (result !== 16'h0000) $display("FAIL lshr_wide: got %h want 0000", result); else passed++;
        issue(OP_ASHU, 16'h0003, 16'h0002, 1'b0, 4'h7, lat);
        total++; if (result !== 16'h000C) $display("FAIL ashu_left: got %h want 000c", result); else passed++;
        issue(OP_ASHU, 16'h8000, 16'hFFF0, 1'b0, 4'h7, lat);
        total++; if (result !== 16'hFFFF) $display("FAIL ashu_neg_fill: got %h want ffff", result); else passed++;
        issue(OP_ASHU, 16'h4000, 16'hFFF0, 1'b0, 4'h7, lat);
        total++; if (result !== 16'h0000) $display("FAIL ashu_pos_fill: got %h want 0000", result); else passed++;
    endtask

`ifdef ALU_MULDIV_EN
    task automatic test_muldiv();
        int lat;
        issue(OP_MUL, 16'h00FF, 16'h0101, 1'b0, 4'h8, lat);
        total++; if (lat !== 18) $display("FAIL mul_latency: got %0d want 18", lat); else passed++;
        total++; if (result !== 16'hFFFF) $display("FAIL mul_result: got %h want ffff", result); else passed++;
        total++; if (flags !== 5'h00) $display("FAIL mul_flags: got %h want 00", flags); else passed++;
        total++; if (tag_out !== 4'h8) $display("FAIL mul_tag: got %h want 8", tag_out); else passed++;
        issue(OP_MUL, 16'h0100, 16'h0100, 1'b0, 4'h9, lat);
        total++; if (result !== 16'h0000 || flags !== 5'h0C) $display("FAIL mul_ovf: got %h/%h want 0000/0c", result, flags); else passed++;
        issue(OP_DIVU, 16'd100, 16'd7, 1'b0, 4'hA, lat);
        total++; if (lat !== 18) $display("FAIL divu_latency: got %0d want 18", lat); else passed++;
        total++; if (result !== 16'd14 || tag_out !== 4'hA) $display("FAIL divu: got %h/%h want 000e/a", result, tag_out); else passed++;
        issue(OP_REMU, 16'd100, 16'd7, 1'b0, 4'hB, lat);
        total++; if (result !== 16'd2 || tag_out !== 4'hB) $display("FAIL remu: got %h/%h want 0002/b", result, tag_out); else passed++;
        issue(OP_DIVU, 16'd5, 16'd0, 1'b0, 4'hC, lat);
        total++; if (lat !== 18) $display("FAIL div0_latency: got %0d want 18", lat); else passed++;
        total++; if (result !== 16'hFFFF || flags !== 5'h04 || tag_out !== 4'hC) $display("FAIL div0: got %h/%h/%h want ffff/04/c", result, flags, tag_out); else passed++;
        issue(OP_REMU, 16'd5, 16'd0, 1'b0, 4'hD, lat);
        total++; if (result !== 16'h0005 || flags !== 5'h04) $display("FAIL rem0: got %h/%h want 0005/04", result, flags); else passed++;
    endtask
`else
    task automatic test_muldiv_disabled();
        int lat;
        issue(OP_MUL, 16'h00FF, 16'h0101, 1'b0, 4'h8, lat);
        total++; if (lat !== 1 || invalid_op !== 1'b1) $display("FAIL mul_off: got lat %0d inv %b want 1/1", lat, invalid_op); else passed++;
        total++; if (result !== 16'h0000 || flags !== 5'h00) $display("FAIL mul_off_result: got %h/%h want 0000/00", result, flags); else passed++;
        issue(OP_DIVU, 16'd100, 16'd7, 1'b0, 4'hA, lat);
        total++; if (lat !== 1 || invalid_op !== 1'b1 || result !== 16'h0000) $display("FAIL divu_off: got lat %0d inv %b res %h", lat, invalid_op, result); else passed++;
        issue(OP_REMU, 16'd100, 16'd7, 1'b0, 4'hB, lat);
        total++; if (lat !== 1 || invalid_op !== 1'b1 || tag_out !== 4'hB) $display("FAIL remu_off: got lat %0d inv %b tag %h", lat, invalid_op, tag_out); else passed++;
    endtask
`endif

    task automatic test_stall();
        int lat;
        logic [3:0] sop;
        logic [W-1:0] sexp;
`ifdef ALU_MULDIV_EN
        sop = OP_MUL; sexp = 16'hFFFF;
`else
        sop = OP_ADD; sexp = 16'h0200;
`endif
        @(posedge clk); #1;
        out_ready = 1'b0;
        issue(sop, 16'h00FF, 16'h0101, 1'b0, 4'h9, lat);
        total++; if (lat < 1) $display("FAIL stall_no_result: got %0d want >=1", lat); else passed++;
        op = OP_ADD; a = 16'h0001; b = 16'h0001; carry_in = 1'b0; tag_in = 4'hA; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b1 || result !== sexp || tag_out !== 4'h9) $display("FAIL stall_hold%0d: got %b/%h/%h want 1/%h/9", i, out_valid, result, tag_out, sexp); else passed++;
            total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready%0d: got %b want 0", i, in_ready); else passed++;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || result !== 16'h0002 || tag_out !== 4'hA) $display("FAIL stall_release: got %b/%h/%h want 1/0002/a", out_valid, result, tag_out); else passed++;
    endtask

    task automatic test_back_to_back();
        op = OP_ADD; a = 16'd1; b = 16'd2; carry_in = 1'b0; tag_in = 4'h1; in_valid = 1'b1;
        @(posedge clk); #1;
        total++; if (result !== 16'd3 || tag_out !== 4'h1 || in_ready !== 1'b1) $display("FAIL b2b_0: got %h/%h/%b want 0003/1/1", result, tag_out, in_ready); else passed++;
        a = 16'd3; b = 16'd4; tag_in = 4'h2;
        @(posedge clk); #1;
        total++; if (result !== 16'd7 || tag_out !== 4'h2 || out_valid !== 1'b1) $display("FAIL b2b_1: got %h/%h/%b want 0007/2/1", result, tag_out, out_valid); else passed++;
        op = OP_SUB; a = 16'd9; b = 16'd4; tag_in = 4'h3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if (result !== 16'd5 || tag_out !== 4'h3 || out_valid !== 1'b1) $display("FAIL b2b_2: got %h/%h/%b want 0005/3/1", result, tag_out, out_valid); else passed++;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) $display("FAIL b2b_drain: got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_reset_mid_op();
        int seen;
`ifdef ALU_MULDIV_EN
        op = OP_MUL; a = 16'h00FF; b = 16'h0101; tag_in = 4'hE; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
`else
        @(posedge clk); #1;
        out_ready = 1'b0;
        op = OP_ADD; a = 16'h0010; b = 16'h0001; tag_in = 4'hE; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
`endif
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        total++; if (out_valid !== 1'b0) $display("FAIL rstmid_out_valid: got %b want 0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL rstmid_in_ready: got %b want 1", in_ready); else passed++;
        total++; if (result !== 16'h0000 || tag_out !== 4'h0) $display("FAIL rstmid_outputs: got %h/%h want 0000/0", result, tag_out); else passed++;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        total++; if (seen !== 0) $display("FAIL rstmid_no_result: got %0d valid cycles want 0", seen); else passed++;
    endtask

    task automatic test_invalid();
        int lat;
        issue(4'd15, 16'h1234, 16'h5678, 1'b1, 4'h6, lat);
        total++; if (lat !== 1) $display("FAIL inv15_latency: got %0d want 1", lat); else passed++;
        total++; if (invalid_op !== 1'b1 || result !== 16'h0000 || flags !== 5'h00) $display("FAIL inv15: got %b/%h/%h want 1/0000/00", invalid_op, result, flags); else passed++;
        total++; if (tag_out !== 4'h6) $display("FAIL inv15_tag: got %h want 6", tag_out); else passed++;
        issue(4'd14, 16'hFFFF, 16'hFFFF, 1'b0, 4'h7, lat);
        total++; if (invalid_op !== 1'b1 || result !== 16'h0000) $display("FAIL inv14: got %b/%h want 1/0000", invalid_op, result); else passed++;
        issue(OP_ADD, 16'h0001, 16'h0001, 1'b0, 4'h8, lat);
        total++; if (invalid_op !== 1'b0 || result !== 16'h0002) $display("FAIL inv_clear: got %b/%h want 0/0002", invalid_op, result); else passed++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_sub_cmp();
        test_logic();
        test_shifts();
`ifdef ALU_MULDIV_EN
        test_muldiv();
`else
        test_muldiv_disabled();
`endif
        test_stall();
        test_back_to_back();
        test_reset_mid_op();
        test_invalid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
